// File: rtl/dcache_mem_bridge_pkg.sv
// Shared types for the D-cache to main-memory bridge: request entry layout,
// bridge FSM states and the bus address alignment helper.
package dcache_mem_bridge_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } dmem_req_t;

  localparam int REQ_W = $bits(dmem_req_t);

  typedef enum logic {
    IDLE,
    WAIT_RD
  } bridge_state_t;

  // Clear the byte-offset bits so the bus only ever sees word addresses.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/dcache_mem_bridge_req_fifo.sv
// Synchronous request FIFO with a combinational head, so a lone entry can
// drive the bus in the cycle right after it is written.
module req_fifo
  import dcache_mem_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [REQ_W-1:0] push_data,
  input  logic             pop,
  output logic             accept,
  output logic             full,
  output logic             empty,
  output logic [REQ_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [REQ_W-1:0] entry_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign pop_ok  = pop && !empty;
  // A push into a full queue still lands when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign accept  = push_ok;
  assign head    = entry_reg[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      entry_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/dcache_mem_bridge.sv
// In-order bridge from the D-cache miss/write-back port to the memory bus,
// one bus transaction at a time, with a watchdog on every outstanding read.
module dcache_mem_bridge
  import dcache_mem_bridge_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_request,
  input  logic            mem_write,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_write_data,
  output logic            mem_ready,
  output logic [XLEN-1:0] mem_data,
  output logic            q_full,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata,
  output logic [1:0]      err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  bridge_state_t    state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             mem_ready_reg, mem_ready_next;
  logic [XLEN-1:0]  mem_data_reg, mem_data_next;
  logic [1:0]       err_reg, err_next;

  dmem_req_t        push_req;
  dmem_req_t        head_req;
  logic [REQ_W-1:0] head_bits;
  logic             enq_any;
  logic             fifo_accept;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             drop;

  // A simultaneous read+write keeps the write; the read is reported as dropped.
  assign enq_any  = mem_write || mem_request;
  assign push_req = '{we: mem_write, addr: word_align(mem_addr), data: mem_write_data};
  assign drop     = (mem_write && mem_request) || (enq_any && !fifo_accept);

  req_fifo #(
    .DEPTH(DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (enq_any),
    .push_data (push_req),
    .pop       (fifo_pop),
    .accept    (fifo_accept),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_bits)
  );

  assign head_req  = dmem_req_t'(head_bits);
  assign bus_req   = (state_reg == IDLE) && !fifo_empty;
  assign fifo_pop  = bus_req && bus_ack;
  assign bus_we    = bus_req && head_req.we;
  assign bus_addr  = bus_req ? head_req.addr : '0;
  assign bus_wdata = bus_req ? head_req.data : '0;
  assign q_full    = fifo_full;
  assign mem_ready = mem_ready_reg;
  assign mem_data  = mem_data_reg;
  assign err       = err_reg;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    mem_ready_next = 1'b0;
    mem_data_next  = mem_data_reg;
    err_next       = {1'b0, drop};
    case (state_reg)
      IDLE: begin
        if (fifo_pop && !head_req.we) begin
          state_next = WAIT_RD;
          cnt_next   = '0;
        end
      end
      WAIT_RD: begin
        cnt_next = cnt_reg + CW'(1);
        // A response on the last watchdog cycle still counts as a real response.
        if (bus_rvalid) begin
          mem_ready_next = 1'b1;
          mem_data_next  = bus_rdata;
          state_next     = IDLE;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          mem_ready_next = 1'b1;
          mem_data_next  = '0;
          err_next[1]    = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mem_ready_reg <= 1'b0;
      mem_data_reg  <= '0;
      err_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      mem_ready_reg <= mem_ready_next;
      mem_data_reg  <= mem_data_next;
      err_reg       <= err_next;
    end
  end

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Scoreboard bench for dcache_mem_bridge: stimulus queues expected bus
// transactions, read returns and error pulses; a negedge monitor checks them.
module tb_dcache_mem_bridge;
  import dcache_mem_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_request, mem_write;
  logic [31:0] mem_addr, mem_write_data;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic        q_full, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack, bus_rvalid;
  logic [31:0] bus_rdata;
  logic [1:0]  err;

  always #5 clk = ~clk;

  dcache_mem_bridge #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_request    (mem_request),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_ready      (mem_ready),
    .mem_data       (mem_data),
    .q_full         (q_full),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_ack        (bus_ack),
    .bus_rvalid     (bus_rvalid),
    .bus_rdata      (bus_rdata),
    .err            (err)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } bus_exp_t;
  typedef struct { logic [31:0] data; logic timeout; } rd_exp_t;

  bus_exp_t    exp_bus[$];
  rd_exp_t     exp_rd[$];
  logic [1:0]  exp_err[$];
  int          errors = 0;
  int          checks = 0;

  // Memory model and responder controls
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] rd_latch = 32'h0;
  int          rd_accepts = 0;
  int          rd_seen = 0;
  int          pend = 0;
  int          rdelay = 1;
  logic        ack_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected 0x%08h expected nothing", name, act);
  endtask

  task automatic exp_b(input logic we, input logic [31:0] a, input logic [31:0] d);
    bus_exp_t e;
    e.we = we; e.addr = a; e.wdata = d;
    exp_bus.push_back(e);
  endtask

  task automatic exp_r(input logic [31:0] d, input logic to);
    rd_exp_t e;
    e.data = d; e.timeout = to;
    exp_rd.push_back(e);
  endtask

  task automatic sync(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; holds the request for exactly one edge.
  task automatic pulse(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    mem_write = w; mem_request = r; mem_addr = a; mem_write_data = d;
    @(posedge clk);
    #1;
    mem_write = 1'b0; mem_request = 1'b0;
  endtask

  task automatic check_zero(input string p);
    chk({p, "_mem_ready"}, {31'd0, mem_ready}, 32'd0);
    chk({p, "_mem_data"},  mem_data, 32'd0);
    chk({p, "_q_full"},    {31'd0, q_full}, 32'd0);
    chk({p, "_bus_req"},   {31'd0, bus_req}, 32'd0);
    chk({p, "_bus_we"},    {31'd0, bus_we}, 32'd0);
    chk({p, "_bus_addr"},  bus_addr, 32'd0);
    chk({p, "_bus_wdata"}, bus_wdata, 32'd0);
    chk({p, "_err"},       {30'd0, err}, 32'd0);
  endtask

  // Responder: ack level and read response after rdelay cycles
  always begin
    @(posedge clk);
    #1;
    bus_ack    = ack_en;
    bus_rvalid = 1'b0;
    if (rd_accepts != rd_seen) begin
      rd_seen = rd_accepts;
      pend    = rdelay;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bus_rvalid = 1'b1;
        bus_rdata  = rd_latch;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin : mon
    bus_exp_t   be;
    rd_exp_t    re;
    logic [1:0] ee;
    if (rst) begin
      if (bus_req && bus_ack) begin
        if (exp_bus.size() == 0) begin
          unexpected("bus_txn", bus_addr);
        end else begin
          be = exp_bus.pop_front();
          chk("bus_we", {31'd0, bus_we}, {31'd0, be.we});
          chk("bus_addr", bus_addr, be.addr);
          if (be.we) chk("bus_wdata", bus_wdata, be.wdata);
        end
        if (bus_we) begin
          bus_mem[bus_addr] = bus_wdata;
        end else begin
          rd_latch = bus_mem.exists(bus_addr) ? bus_mem[bus_addr] : 32'hBADBAD00;
          rd_accepts++;
        end
      end
      if (mem_ready) begin
        if (exp_rd.size() == 0) begin
          unexpected("mem_ready", mem_data);
        end else begin
          re = exp_rd.pop_front();
          chk("mem_data", mem_data, re.data);
          chk("rd_timeout_err", {31'd0, err[1]}, {31'd0, re.timeout});
        end
      end
      if (err != 2'b00) begin
        if (exp_err.size() == 0) begin
          unexpected("err", {30'd0, err});
        end else begin
          ee = exp_err.pop_front();
          chk("err", {30'd0, err}, {30'd0, ee});
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "bench time limit");
  end

  initial begin : main
    logic [31:0] t3_addr [4];
    logic [31:0] t3_bus  [4];
    logic [31:0] t3_data [4];
    int n;
    t3_addr = '{32'h100, 32'h104, 32'h108, 32'h10F};
    t3_bus  = '{32'h100, 32'h104, 32'h108, 32'h10C};
    t3_data = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    rst = 1'b0; mem_request = 1'b0; mem_write = 1'b0;
    mem_addr = '0; mem_write_data = '0;
    bus_ack = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    sync(1);
    rst = 1'b1;

    // Single read, minimum latency
    bus_mem[32'h2040] = 32'hAABBCCDD;
    ack_en = 1'b1; rdelay = 1;
    sync(2);
    exp_b(1'b0, 32'h2040, 32'h0);
    exp_r(32'hAABBCCDD, 1'b0);
    pulse(1'b0, 1'b1, 32'h2040, 32'h0);
    @(negedge clk); chk("t1_bus_req", {31'd0, bus_req}, 32'd1);
    chk("t1_ready_c1", {31'd0, mem_ready}, 32'd0);
    @(negedge clk); chk("t1_wait_no_req", {31'd0, bus_req}, 32'd0);
    chk("t1_ready_c2", {31'd0, mem_ready}, 32'd0);
    @(negedge clk); chk("t1_ready_c3", {31'd0, mem_ready}, 32'd1);
    @(negedge clk); chk("t1_ready_c4", {31'd0, mem_ready}, 32'd0);
    sync(2);

    // Write-back then read of the same address
    exp_b(1'b1, 32'h30, 32'h87654321);
    exp_b(1'b0, 32'h30, 32'h0);
    exp_r(32'h87654321, 1'b0);
    pulse(1'b1, 1'b0, 32'h30, 32'h87654321);
    pulse(1'b0, 1'b1, 32'h30, 32'h0);
    sync(6);

    // Fill with ack low, then overflow
    ack_en = 1'b0;
    sync(2);
    for (int i = 0; i < 4; i++) begin
      bus_mem[t3_bus[i]] = t3_data[i];
      exp_b(1'b0, t3_bus[i], 32'h0);
      exp_r(t3_data[i], 1'b0);
    end
    for (int i = 0; i < 4; i++) pulse(1'b0, 1'b1, t3_addr[i], 32'h0);
    @(negedge clk); chk("t3_q_full_4", {31'd0, q_full}, 32'd1);
    exp_err.push_back(2'b01);
    sync(1);
    pulse(1'b0, 1'b1, 32'h110, 32'h0);
    @(negedge clk); chk("t3_q_full_after_drop", {31'd0, q_full}, 32'd1);
    sync(1);
    ack_en = 1'b1;
    sync(20);
    @(negedge clk); chk("t3_q_full_drained", {31'd0, q_full}, 32'd0);
    sync(1);

    // Read timeout, late response ignored
    rdelay = 70;
    exp_b(1'b0, 32'h400, 32'h0);
    exp_r(32'h0, 1'b1);
    exp_err.push_back(2'b10);
    pulse(1'b0, 1'b1, 32'h400, 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_ready && n < 200);
    chk("t4_timeout_latency", n, 32'd66);
    sync(20);

    // Simultaneous read and write: only the write goes out
    rdelay = 1;
    exp_b(1'b1, 32'h1030, 32'hCAFEF00D);
    exp_err.push_back(2'b01);
    pulse(1'b1, 1'b1, 32'h1030, 32'hCAFEF00D);
    sync(5);

    // Reset while waiting on a read with two entries queued
    rdelay = 5;
    exp_b(1'b0, 32'h500, 32'h0);
    exp_b(1'b0, 32'h504, 32'h0);
    exp_b(1'b0, 32'h508, 32'h0);
    pulse(1'b0, 1'b1, 32'h500, 32'h0);
    pulse(1'b0, 1'b1, 32'h504, 32'h0);
    pulse(1'b0, 1'b1, 32'h508, 32'h0);
    chk("t6_first_issued", exp_bus.size(), 32'd2);
    rst = 1'b0;
    exp_bus.delete();
    sync(1);
    rst = 1'b1;
    @(negedge clk);
    check_zero("t6_after_reset");
    sync(10);
    @(negedge clk); chk("t6_queue_empty", {31'd0, bus_req}, 32'd0);

    chk("end_exp_bus_left", exp_bus.size(), 32'd0);
    chk("end_exp_rd_left", exp_rd.size(), 32'd0);
    chk("end_exp_err_left", exp_err.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
